// File: rtl/mult_iter_hs.sv
// mult_iter_hs : iterative WIDTH x WIDTH multiplier with valid/ready handshakes.
//   Retires BPC multiplier bits per BUSY cycle (N = WIDTH/BPC cycles per op),
//   supports unsigned and two's-complement signed operands, and presents the
//   2*WIDTH product as out1 (low word) / out2 (high word) plus an overflow flag.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   clr                 synchronous abort back to IDLE (data outputs hold)
//   in_valid/in_ready   operand handshake for a, b, sgn
//   a, b                multiplicand / multiplier (WIDTH bits)
//   sgn                 1 = signed operands, 0 = unsigned
//   out_valid/out_ready result handshake for out1, out2, of
//   out1, out2          product low / high word
//   of                  product does not fit in WIDTH bits
module mult_iter_hs #(
  parameter int WIDTH = 16,
  parameter int BPC   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sgn,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out1,
  output logic [WIDTH-1:0] out2,
  output logic             of
);

  localparam int N     = WIDTH / BPC;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                     state;
  state_t                     state_nxt;
  logic [CNT_W-1:0]           cnt;
  logic [WIDTH-1:0]           a_mag;
  logic [WIDTH-1:0]           b_mag;
  logic                       neg;
  logic                       sgn_q;
  logic [2*WIDTH-1:0]         acc;
  logic [2*WIDTH-1:0]         part;
  logic [2*WIDTH-1:0]         sum;
  logic signed [2*WIDTH-1:0]  prod;
  logic                       last;

  // Magnitude of a signed operand as WIDTH-bit unsigned; -2^(WIDTH-1) maps exactly.
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x, input logic s);
    return (s && x[WIDTH-1]) ? (~x + WIDTH'(1)) : x;
  endfunction

  function automatic logic signed [2*WIDTH-1:0] fix_sign(input logic [2*WIDTH-1:0] p,
                                                         input logic n);
    return n ? $signed(~p + (2*WIDTH)'(1)) : $signed(p);
  endfunction

  function automatic logic ovf(input logic signed [2*WIDTH-1:0] p, input logic s);
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    hi = p[2*WIDTH-1:WIDTH];
    lo = p[WIDTH-1:0];
    return s ? (hi != {WIDTH{lo[WIDTH-1]}}) : (|hi);
  endfunction

  // Partial product for this step: |a| times the next BPC bits of |b|, aligned to its weight.
  always_comb begin
    part = ({{WIDTH{1'b0}}, a_mag} * {{(2*WIDTH-BPC){1'b0}}, b_mag[BPC-1:0]}) << (BPC * cnt);
    sum  = acc + part;
    prod = fix_sign(sum, neg);
    last = (cnt == CNT_W'(N - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = BUSY;
      end
      BUSY: begin
        if (last) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (clr) state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      a_mag <= '0;
      b_mag <= '0;
      neg   <= 1'b0;
      sgn_q <= 1'b0;
      acc   <= '0;
      out1  <= '0;
      out2  <= '0;
      of    <= 1'b0;
    end else if (!clr) begin
      if (state == IDLE && in_valid) begin
        a_mag <= mag(a, sgn);
        b_mag <= mag(b, sgn);
        neg   <= sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
        sgn_q <= sgn;
        acc   <= '0;
        cnt   <= '0;
      end else if (state == BUSY) begin
        acc   <= sum;
        b_mag <= b_mag >> BPC;
        cnt   <= cnt + CNT_W'(1);
        // Last step: publish the sign-corrected product.
        if (last) begin
          out1 <= prod[WIDTH-1:0];
          out2 <= prod[2*WIDTH-1:WIDTH];
          of   <= ovf(prod, sgn_q);
        end
      end
    end
  end

endmodule

// File: tb/tb_mult_iter_hs.sv
// tb_mult_iter_hs : directed checks on a WIDTH=16/BPC=4 instance plus
// randomized scoreboard runs on instances with BPC = 1, 2, 4, 16.
module tb_mult_iter_hs;

  localparam int W  = 16;
  localparam int DN = 4;   // steps for the directed instance (BPC=4)

  logic clk = 1'b0;
  int   cyc = 0;
  int   pass_cnt = 0;
  int   total_cnt = 0;
  logic rst_n_r = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Reference: true integer product, truncated to 2*W bits; overflow = not representable in W bits.
  function automatic logic [2*W:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y,
                                            input logic s);
    longint     xv, yv, p;
    logic [63:0] pu;
    logic       o;
    xv = s ? longint'($signed(x)) : longint'(x);
    yv = s ? longint'($signed(y)) : longint'(y);
    p  = xv * yv;
    pu = p;
    o  = s ? (p < -32768 || p > 32767) : (p > 65535);
    return {o, pu[2*W-1:0]};
  endfunction

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 7))
      0: return 16'h0000;
      1: return 16'hFFFF;
      2: return 16'h8000;
      3: return 16'h7FFF;
      4: return 16'h0001;
      default: return W'($urandom);
    endcase
  endfunction

  // ---------------- directed instance ----------------
  logic         d_rst_n = 1'b0;
  logic         d_clr = 1'b0;
  logic         d_iv = 1'b0;
  logic         d_ir;
  logic [W-1:0] d_a = '0;
  logic [W-1:0] d_b = '0;
  logic         d_sgn = 1'b0;
  logic         d_ov;
  logic         d_ordy = 1'b0;
  logic [W-1:0] d_o1;
  logic [W-1:0] d_o2;
  logic         d_of;

  mult_iter_hs #(.WIDTH(W), .BPC(4)) u_dir (
    .clk(clk), .rst_n(d_rst_n), .clr(d_clr), .in_valid(d_iv), .in_ready(d_ir),
    .a(d_a), .b(d_b), .sgn(d_sgn), .out_valid(d_ov), .out_ready(d_ordy),
    .out1(d_o1), .out2(d_o2), .of(d_of)
  );

  task automatic d_run(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
    @(negedge clk);
    chk("idle_in_ready", d_ir, 1);
    d_a = x; d_b = y; d_sgn = s; d_iv = 1'b1;
    @(negedge clk);
    d_iv = 1'b0; d_a = W'($urandom); d_b = W'($urandom); d_sgn = ~s;
    chk("busy_in_ready", d_ir, 0);
    repeat (DN - 1) @(negedge clk);
    chk("early_out_valid", d_ov, 0);
    @(negedge clk);
    chk("latency_out_valid", d_ov, 1);
  endtask

  task automatic d_take();
    d_ordy = 1'b1;
    @(negedge clk);
    d_ordy = 1'b0;
    chk("post_take_out_valid", d_ov, 0);
    chk("post_take_in_ready", d_ir, 1);
  endtask

  task automatic d_res(input string nm, input logic [W-1:0] e2, input logic [W-1:0] e1,
                       input logic eo);
    chk({nm, "_out2"}, d_o2, e2);
    chk({nm, "_out1"}, d_o1, e1);
    chk({nm, "_of"}, d_of, eo);
  endtask

  // ---------------- randomized instances ----------------
  genvar g;
  for (g = 0; g < 4; g++) begin : gr
    localparam int BP = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 4 : 16;
    localparam int NOPS = 1000;
    logic         iv = 1'b0;
    logic         ir;
    logic [W-1:0] ra = '0;
    logic [W-1:0] rb = '0;
    logic         rs = 1'b0;
    logic         ov;
    logic         ordy = 1'b0;
    logic [W-1:0] o1;
    logic [W-1:0] o2;
    logic         rof;
    logic         zero = 1'b0;
    logic         done = 1'b0;
    logic [2*W:0] expq[$];
    int           accq[$];

    mult_iter_hs #(.WIDTH(W), .BPC(BP)) u_dut (
      .clk(clk), .rst_n(rst_n_r), .clr(zero), .in_valid(iv), .in_ready(ir),
      .a(ra), .b(rb), .sgn(rs), .out_valid(ov), .out_ready(ordy),
      .out1(o1), .out2(o2), .of(rof)
    );

    initial begin : drive
      int ops;
      ops = 0;
      wait (rst_n_r === 1'b1);
      while (ops < NOPS) begin
        @(negedge clk);
        if (ir) begin
          if ($urandom_range(0, 3) != 0) begin
            ra = pick(); rb = pick(); rs = 1'($urandom);
            iv = 1'b1;
            expq.push_back(ref_mul(ra, rb, rs));
            accq.push_back(cyc + 1);
            ops++;
          end else begin
            iv = 1'b0;
          end
        end else begin
          iv = 1'($urandom); ra = W'($urandom); rb = W'($urandom); rs = 1'($urandom);
        end
      end
      @(negedge clk);
      iv = 1'b0;
      for (int i = 0; i < 200 && expq.size() != 0; i++) @(negedge clk);
      if (expq.size() != 0) chk("drain_timeout", 64'(expq.size()), 0);
      done = 1'b1;
    end

    initial begin : monitor
      logic         seen;
      logic [2*W:0] e;
      int           ac;
      seen = 1'b0;
      forever begin
        @(negedge clk);
        if (ov) begin
          if (!seen) begin
            if (expq.size() == 0) begin
              chk("unexpected_out_valid", 1, 0);
            end else begin
              e  = expq.pop_front();
              ac = accq.pop_front();
              chk($sformatf("rand_bpc%0d_result", BP), {rof, o2, o1}, e);
              chk($sformatf("rand_bpc%0d_latency", BP), 64'(cyc - ac), 64'(W / BP));
            end
            seen = 1'b1;
          end
          ordy = 1'($urandom);
          if (ordy) seen = 1'b0;
        end else begin
          ordy = 1'($urandom);
        end
      end
    end
  end

  // ---------------- directed sequence and wrap-up ----------------
  initial begin
    repeat (2) @(negedge clk);
    chk("reset_in_ready", d_ir, 1);
    chk("reset_out_valid", d_ov, 0);
    d_res("reset", 16'h0000, 16'h0000, 1'b0);
    d_rst_n = 1'b1;
    rst_n_r = 1'b1;

    d_run(16'hFFFF, 16'hFFFF, 1'b0);
    d_res("u_ffff_sq", 16'hFFFE, 16'h0001, 1'b1);
    d_take();

    d_run(16'hFFFD, 16'h0005, 1'b1);
    d_res("s_m3x5", 16'hFFFF, 16'hFFF1, 1'b0);
    d_take();

    d_run(16'h8000, 16'h8000, 1'b1);
    d_res("s_8000_sq", 16'h4000, 16'h0000, 1'b1);
    d_take();

    d_run(16'h8000, 16'h8000, 1'b0);
    d_res("u_8000_sq", 16'h4000, 16'h0000, 1'b1);
    d_take();

    d_run(16'h0000, 16'h1234, 1'b0);
    d_res("zero_op", 16'h0000, 16'h0000, 1'b0);
    d_take();

    // Back-pressure: result held, new operands ignored.
    d_run(16'd7, 16'd9, 1'b0);
    d_iv = 1'b1; d_a = 16'd5; d_b = 16'd5;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_out_valid", d_ov, 1);
      chk("bp_in_ready", d_ir, 0);
      chk("bp_out1", d_o1, 16'd63);
      chk("bp_out2", d_o2, 16'd0);
    end
    d_iv = 1'b0;
    d_take();
    @(negedge clk);
    chk("bp_stays_idle", d_ir, 1);

    // Abort mid-BUSY.
    d_a = 16'd3; d_b = 16'd3; d_sgn = 1'b0; d_iv = 1'b1;
    @(negedge clk);
    d_iv = 1'b0;
    @(negedge clk);
    d_clr = 1'b1;
    @(negedge clk);
    d_clr = 1'b0;
    chk("clr_in_ready", d_ir, 1);
    chk("clr_out_valid", d_ov, 0);
    repeat (DN + 2) @(negedge clk);
    chk("clr_no_result", d_ov, 0);
    chk("clr_out1_held", d_o1, 16'd63);

    // clr beats in_valid in IDLE.
    d_clr = 1'b1; d_iv = 1'b1; d_a = 16'd2; d_b = 16'd2;
    @(negedge clk);
    d_clr = 1'b0; d_iv = 1'b0;
    chk("clr_iv_not_captured", d_ir, 1);
    repeat (DN + 1) @(negedge clk);
    chk("clr_iv_no_result", d_ov, 0);

    // Async reset mid-BUSY (step count 2).
    d_a = 16'hFFFF; d_b = 16'hFFFF; d_iv = 1'b1;
    @(negedge clk);
    d_iv = 1'b0;
    repeat (2) @(negedge clk);
    #2 d_rst_n = 1'b0;
    #1;
    chk("arst_out_valid", d_ov, 0);
    chk("arst_in_ready", d_ir, 1);
    d_res("arst", 16'h0000, 16'h0000, 1'b0);
    @(negedge clk);
    d_rst_n = 1'b1;

    for (int i = 0; i < 90000 && !(gr[0].done && gr[1].done && gr[2].done && gr[3].done); i++)
      @(negedge clk);
    if (!(gr[0].done && gr[1].done && gr[2].done && gr[3].done))
      chk("random_timeout", 0, 1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
